// File: rtl/line_fill_engine_pkg.sv
// Shared types for the line fill engine: fetch command encoding, FSM states,
// the debug view of the engine and a saturating counter helper.
package line_fill_pkg;

    typedef enum logic [1:0] {
        CMD_NOP      = 2'b00,
        CMD_FETCH    = 2'b01,
        CMD_WB_FETCH = 2'b10
    } fetch_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_DATA,
        RD_REQ,
        RD_DATA,
        DONE
    } lfe_state_t;

    typedef struct packed {
        lfe_state_t state;
        logic [1:0] cmd;
    } lfe_dbg_t;

    localparam int unsigned PERF_W = 32;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/line_fill_engine_if.sv
// Bundle of the fetch command port, the cache data memory port and the
// external burst bus seen by the line fill engine.
interface line_fill_engine_if #(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int list_width = 32,
    parameter int data_width = 32
);
    localparam int tag_w   = $clog2(list_depth);
    localparam int maddr_w = $clog2(list_depth) + $clog2(list_width);

    // Every valid/ready (req/gnt, ren/rready, wen/wready, ...) pair transfers
    // on a clock edge where both are high; a raised valid with its payload
    // stays unchanged until that edge.
    logic                  fetch_req;
    logic                  fetch_gnt;
    logic [1:0]            fetch_cmd;
    logic [tag_w-1:0]      fetch_tag;
    logic [addr_width-1:0] fetch_addr;
    logic [addr_width-1:0] fetch_addr_pre;
    logic                  fetch_done;

    logic                  mem_ren;
    logic [maddr_w-1:0]    mem_raddr;
    logic                  mem_rready;
    logic [data_width-1:0] mem_rdata;
    logic                  mem_rdata_valid;
    logic                  mem_wen;
    logic [maddr_w-1:0]    mem_waddr;
    logic [data_width-1:0] mem_wdata;
    logic                  mem_wready;

    logic                  ext_req_valid;
    logic                  ext_req_ready;
    logic                  ext_req_we;
    logic [addr_width-1:0] ext_req_addr;
    logic                  ext_wvalid;
    logic                  ext_wready;
    logic [data_width-1:0] ext_wdata;
    logic                  ext_wlast;
    logic                  ext_rvalid;
    logic                  ext_rready;
    logic [data_width-1:0] ext_rdata;

    modport slave (
        input  fetch_req, fetch_cmd, fetch_tag, fetch_addr, fetch_addr_pre,
        output fetch_gnt, fetch_done,
        output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
        input  mem_rready, mem_rdata, mem_rdata_valid, mem_wready,
        output ext_req_valid, ext_req_we, ext_req_addr,
        output ext_wvalid, ext_wdata, ext_wlast, ext_rready,
        input  ext_req_ready, ext_wready, ext_rvalid, ext_rdata
    );

    modport master (
        output fetch_req, fetch_cmd, fetch_tag, fetch_addr, fetch_addr_pre,
        input  fetch_gnt, fetch_done,
        input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
        output mem_rready, mem_rdata, mem_rdata_valid, mem_wready,
        input  ext_req_valid, ext_req_we, ext_req_addr,
        input  ext_wvalid, ext_wdata, ext_wlast, ext_rready,
        output ext_req_ready, ext_wready, ext_rvalid, ext_rdata
    );

endinterface

// File: rtl/line_fill_engine_wb_buffer.sv
// One-entry data buffer with valid/ready on both sides; decouples cache
// reads from write-back beats on the external bus.
module lfe_wb_buffer
    import line_fill_pkg::*;
#(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [data_width-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [data_width-1:0] out_data_o
);

    logic                  full_q, full_d;
    logic [data_width-1:0] data_q, data_d;

    // Accept while empty, or while the held word leaves in this same cycle.
    assign in_ready_o  = !full_q || out_ready_i;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (full_q && out_ready_i) begin
            full_d = 1'b0;
        end
        if (in_valid_i && in_ready_o) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/line_fill_engine.sv
// Line fill engine: optional victim write-back followed by a line refill.
// Macro LINE_FILL_PERF_CNT_EN adds saturating fetch / write-back counters.
module line_fill_engine
    import line_fill_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int list_width = 32,
    parameter int data_width = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    line_fill_engine_if.slave  bus,
    output lfe_dbg_t           dbg_o
`ifdef LINE_FILL_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_wb_cnt
`endif
);

    localparam int tag_w = $clog2(list_depth);
    localparam int off_w = $clog2(list_width);
    localparam logic [off_w-1:0] last_idx = off_w'(list_width - 1);

    lfe_state_t cs_q, ns_d;

    logic [1:0]            cmd_q;
    logic [tag_w-1:0]      tag_q;
    logic [addr_width-1:0] addr_q;
    logic [addr_width-1:0] addr_pre_q;
    logic [off_w-1:0]      rd_cnt_q, rd_cnt_d;
    logic [off_w-1:0]      beat_cnt_q, beat_cnt_d;
    logic [off_w-1:0]      wr_cnt_q, wr_cnt_d;
    logic                  rd_done_q, rd_done_d;
    logic                  rd_pend_q, rd_pend_d;

    logic                  accept;
    logic                  in_wb, in_rd;
    logic                  rd_issue, rd_acc;
    logic                  wb_beat, wb_last;
    logic                  rd_beat, rd_last;
    logic                  buf_in_ready;
    logic                  buf_out_valid;
    logic [data_width-1:0] buf_out_data;

    assign accept  = (cs_q == IDLE) && bus.fetch_req;
    assign in_wb   = (cs_q == WB_DATA);
    assign in_rd   = (cs_q == RD_DATA);

    // Only one cache read in flight, and only when its word has a free slot.
    assign rd_issue = in_wb && !rd_done_q && !rd_pend_q && buf_in_ready;
    assign rd_acc   = rd_issue && bus.mem_rready;

    assign wb_beat = in_wb && buf_out_valid && bus.ext_wready;
    assign wb_last = wb_beat && (beat_cnt_q == last_idx);
    assign rd_beat = in_rd && bus.ext_rvalid && bus.mem_wready;
    assign rd_last = rd_beat && (wr_cnt_q == last_idx);

    lfe_wb_buffer #(
        .data_width (data_width)
    ) u_wb_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_wb && bus.mem_rdata_valid),
        .in_ready_o  (buf_in_ready),
        .in_data_i   (bus.mem_rdata),
        .out_valid_o (buf_out_valid),
        .out_ready_i (bus.ext_wready),
        .out_data_o  (buf_out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q <= IDLE;
        end else begin
            cs_q <= ns_d;
        end
    end

    always_comb begin
        ns_d = cs_q;
        unique case (cs_q)
            IDLE: begin
                if (bus.fetch_req) begin
                    case (bus.fetch_cmd)
                        CMD_WB_FETCH: ns_d = WB_REQ;
                        CMD_FETCH:    ns_d = RD_REQ;
                        default:      ns_d = DONE;
                    endcase
                end
            end
            WB_REQ:  if (bus.ext_req_ready) ns_d = WB_DATA;
            WB_DATA: if (wb_last)           ns_d = RD_REQ;
            RD_REQ:  if (bus.ext_req_ready) ns_d = RD_DATA;
            RD_DATA: if (rd_last)           ns_d = DONE;
            DONE:                           ns_d = IDLE;
            default:                        ns_d = IDLE;
        endcase
    end

    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        beat_cnt_d = beat_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        rd_done_d  = rd_done_q;
        rd_pend_d  = rd_pend_q;

        if ((cs_q == WB_REQ) && bus.ext_req_ready) begin
            rd_cnt_d   = '0;
            beat_cnt_d = '0;
            rd_done_d  = 1'b0;
        end
        if (rd_acc) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == last_idx) begin
                rd_done_d = 1'b1;
            end
        end
        if (wb_beat) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end

        if (bus.mem_rdata_valid) begin
            rd_pend_d = 1'b0;
        end
        if (rd_acc) begin
            rd_pend_d = 1'b1;
        end

        if ((cs_q == RD_REQ) && bus.ext_req_ready) begin
            wr_cnt_d = '0;
        end
        if (rd_beat) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            tag_q      <= '0;
            addr_q     <= '0;
            addr_pre_q <= '0;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            wr_cnt_q   <= '0;
            rd_done_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_done_q  <= rd_done_d;
            rd_pend_q  <= rd_pend_d;
            if (accept) begin
                cmd_q      <= bus.fetch_cmd;
                tag_q      <= bus.fetch_tag;
                addr_q     <= bus.fetch_addr;
                addr_pre_q <= bus.fetch_addr_pre;
            end
        end
    end

    assign bus.fetch_gnt  = (cs_q == IDLE);
    assign bus.fetch_done = (cs_q == DONE);

    assign bus.ext_req_valid = (cs_q == WB_REQ) || (cs_q == RD_REQ);
    assign bus.ext_req_we    = (cs_q == WB_REQ);
    assign bus.ext_req_addr  = (cs_q == WB_REQ) ? addr_pre_q :
                               (cs_q == RD_REQ) ? addr_q : '0;

    assign bus.mem_ren   = rd_issue;
    assign bus.mem_raddr = in_wb ? {tag_q, rd_cnt_q} : '0;

    assign bus.ext_wvalid = in_wb && buf_out_valid;
    assign bus.ext_wdata  = buf_out_data;
    assign bus.ext_wlast  = in_wb && buf_out_valid && (beat_cnt_q == last_idx);

    // Refill beats pass straight through; the cache write port paces the bus.
    assign bus.ext_rready = in_rd && bus.mem_wready;
    assign bus.mem_wen    = in_rd && bus.ext_rvalid;
    assign bus.mem_waddr  = in_rd ? {tag_q, wr_cnt_q} : '0;
    assign bus.mem_wdata  = in_rd ? bus.ext_rdata : '0;

    assign dbg_o.state = cs_q;
    assign dbg_o.cmd   = cmd_q;

`ifdef LINE_FILL_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_wb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_wb_q    <= '0;
        end else begin
            if (cs_q == DONE) begin
                perf_fetch_q <= sat_inc(perf_fetch_q);
            end
            if (wb_last) begin
                perf_wb_q <= sat_inc(perf_wb_q);
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_wb_cnt    = perf_wb_q;
`endif

endmodule

// File: tb/tb_line_fill_engine.sv
// Self-checking bench for line_fill_engine with behavioural cache memory and
// external bus models; expectations are queued when each fetch is driven.
`timescale 1ns/1ps
module tb_line_fill_engine;
    import line_fill_pkg::*;

    localparam int AW = 32;
    localparam int LD = 4;
    localparam int LW = 32;
    localparam int DW = 32;
    localparam int MW = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_fill_engine_if #(.addr_width(AW), .list_depth(LD), .list_width(LW), .data_width(DW)) bus ();
    lfe_dbg_t dbg;
`ifdef LINE_FILL_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wb_cnt;
`endif

    line_fill_engine #(.addr_width(AW), .list_depth(LD), .list_width(LW), .data_width(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .dbg_o (dbg)
`ifdef LINE_FILL_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_wb_cnt    (perf_wb_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0]    exp_q[$];
    logic [AW:0]      req_q[$];
    logic [MW+DW-1:0] mw_q[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a, input int i);
        return a ^ (32'h9E37_0000 + 32'(i));
    endfunction

    // ---------------- bus / memory models ----------------
    logic [DW-1:0] cache_mem [0:127];
    int            outst = 0;
    bit            rsp_pend = 0;
    logic [MW-1:0] rsp_addr = '0;
    logic [MW-1:0] rd_next = '0;
    int            cur_tag = 0;
    bit            rd_active = 0;
    int            rbeat = 0;
    logic [AW-1:0] rd_addr = '0;
    int            wb_beat = 0;
    bit            rand_rdy = 0;
    bit            toggle_wr = 0;
    bit            stall_en = 0;
    int            stall_left = 0;
    int            activity = 0;
    bit            prev_req_pend = 0;
    logic [AW:0]   prev_req = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_ren || bus.mem_wen || bus.ext_req_valid || bus.ext_wvalid) activity++;
            if (bus.mem_rdata_valid) outst--;
            if (bus.mem_ren && bus.mem_rready) begin
                check_val("rd_outstanding", 64'(outst), 64'd0);
                check_val("mem_raddr", 64'(bus.mem_raddr), 64'(rd_next));
                outst++;
                rd_next  = rd_next + 1'b1;
                rsp_pend = 1'b1;
                rsp_addr = bus.mem_raddr;
            end
            if (prev_req_pend)
                check_val("req_hold", 64'({bus.ext_req_valid, bus.ext_req_we, bus.ext_req_addr}),
                          64'({1'b1, prev_req}));
            prev_req_pend = bus.ext_req_valid && !bus.ext_req_ready;
            prev_req      = {bus.ext_req_we, bus.ext_req_addr};
            if (bus.ext_req_valid && bus.ext_req_ready) begin
                check_val("req_q_nonempty", 64'(req_q.size() != 0), 64'd1);
                if (req_q.size() != 0)
                    check_val("ext_req", 64'({bus.ext_req_we, bus.ext_req_addr}), 64'(req_q.pop_front()));
                if (bus.ext_req_we) begin
                    wb_beat = 0;
                    rd_next = MW'(cur_tag * LW);
                end else begin
                    rd_active = 1'b1;
                    rbeat     = 0;
                    rd_addr   = bus.ext_req_addr;
                end
            end
            if (bus.ext_wvalid && bus.ext_wready) begin
                check_val("wlast", 64'(bus.ext_wlast), 64'(wb_beat == LW - 1));
                check_val("wb_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    check_val("wb_data", 64'(bus.ext_wdata), 64'(exp_q.pop_front()));
                wb_beat++;
            end
            if (rd_active && !bus.mem_wready) begin
                check_val("stall_rready", 64'(bus.ext_rready), 64'd0);
                if (mw_q.size() != 0)
                    check_val("stall_waddr", 64'(bus.mem_waddr), 64'(mw_q[0][MW+DW-1:DW]));
            end
            if (bus.mem_wen && bus.mem_wready) begin
                check_val("mw_q_nonempty", 64'(mw_q.size() != 0), 64'd1);
                if (mw_q.size() != 0)
                    check_val("mem_write", 64'({bus.mem_waddr, bus.mem_wdata}), 64'(mw_q.pop_front()));
                cache_mem[bus.mem_waddr] = bus.mem_wdata;
            end
            if (bus.ext_rvalid && bus.ext_rready) begin
                rbeat++;
                if (rbeat == LW) rd_active = 1'b0;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            rsp_pend = 1'b0;
            outst = 0;
            rd_active = 1'b0;
            prev_req_pend = 1'b0;
            bus.mem_rready = 1'b0;
            bus.mem_rdata_valid = 1'b0;
            bus.mem_rdata = '0;
            bus.mem_wready = 1'b0;
            bus.ext_req_ready = 1'b0;
            bus.ext_wready = 1'b0;
            bus.ext_rvalid = 1'b0;
            bus.ext_rdata = '0;
        end else begin
            bus.mem_rdata_valid = rsp_pend;
            bus.mem_rdata = rsp_pend ? cache_mem[rsp_addr] : '0;
            rsp_pend = 1'b0;
            bus.mem_rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ext_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ext_wready = toggle_wr ? ~bus.ext_wready : 1'b1;
            bus.ext_rvalid = rd_active && (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            bus.ext_rdata = rd_pat(rd_addr, rbeat);
            if (stall_en && rd_active && rbeat == 12 && stall_left > 0) begin
                bus.mem_wready = 1'b0;
                stall_left--;
            end else begin
                bus.mem_wready = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_quiet(input string t);
        check_val({t, "_ctrl"}, 64'({bus.fetch_gnt, bus.fetch_done, bus.mem_ren, bus.mem_wen,
                  bus.ext_req_valid, bus.ext_wvalid, bus.ext_wlast, bus.ext_rready}), 64'h80);
        check_val({t, "_addr"}, 64'({bus.mem_raddr, bus.mem_waddr, bus.ext_req_we, bus.ext_req_addr}), 64'h0);
        check_val({t, "_data"}, 64'({bus.mem_wdata, bus.ext_wdata}), 64'h0);
    endtask

    task automatic issue_fetch(input logic [1:0] cmd, input int tag, input logic [AW-1:0] addr,
                               input logic [AW-1:0] pre);
        if (cmd == 2'b10) begin
            req_q.push_back({1'b1, pre});
            for (int i = 0; i < LW; i++) exp_q.push_back(cache_mem[tag * LW + i]);
        end
        if (cmd == 2'b10 || cmd == 2'b01) begin
            req_q.push_back({1'b0, addr});
            for (int i = 0; i < LW; i++) mw_q.push_back({MW'(tag * LW + i), rd_pat(addr, i)});
        end
        cur_tag = tag;
        @(posedge clk);
        #1;
        bus.fetch_req = 1'b1;
        bus.fetch_cmd = cmd;
        bus.fetch_tag = 2'(tag);
        bus.fetch_addr = addr;
        bus.fetch_addr_pre = pre;
        @(negedge clk);
        check_val("fetch_gnt", 64'(bus.fetch_gnt), 64'd1);
        @(posedge clk);
        #1;
        bus.fetch_req = 1'b0;
        bus.fetch_cmd = 2'b00;
    endtask

    task automatic do_fetch(input logic [1:0] cmd, input int tag, input logic [AW-1:0] addr,
                            input logic [AW-1:0] pre, input int exp_lat);
        int  n;
        int  act0;
        bit  done;
        act0 = activity;
        issue_fetch(cmd, tag, addr, pre);
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            done = bus.fetch_done;
            if (n == 1) check_val("gnt_busy", 64'(bus.fetch_gnt), 64'd0);
        end
        check_val("done_seen", 64'(done), 64'd1);
        if (exp_lat > 0) check_val("done_latency", 64'(n), 64'(exp_lat));
        @(negedge clk);
        check_val("done_one_pulse", 64'(bus.fetch_done), 64'd0);
        check_val("gnt_after_done", 64'(bus.fetch_gnt), 64'd1);
        check_val("req_q_drained", 64'(req_q.size()), 64'd0);
        check_val("wb_q_drained", 64'(exp_q.size()), 64'd0);
        check_val("mw_q_drained", 64'(mw_q.size()), 64'd0);
        if (cmd == 2'b11) check_val("nop_activity", 64'(activity - act0), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 128; i++) cache_mem[i] = 32'hC000_0000 + 32'(i);
        bus.fetch_req = 1'b0;
        bus.fetch_cmd = 2'b00;
        bus.fetch_tag = '0;
        bus.fetch_addr = '0;
        bus.fetch_addr_pre = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_fetch(2'b01, 2, 32'h0000_1000, 32'h0, 2 + LW);
        do_fetch(2'b10, 1, 32'h0000_3000, 32'h0000_2000, 0);

        toggle_wr = 1'b1;
        rand_rdy = 1'b1;
        do_fetch(2'b10, 2, 32'h0000_6000, 32'h0000_1000, 0);
        toggle_wr = 1'b0;
        rand_rdy = 1'b0;

        stall_en = 1'b1;
        stall_left = 5;
        do_fetch(2'b01, 3, 32'h0000_7000, 32'h0, 2 + LW + 5);
        check_val("stall_applied", 64'(stall_left), 64'd0);
        stall_en = 1'b0;

        do_fetch(2'b11, 0, 32'h0000_8000, 32'h0000_9000, 1);

        begin
            int n;
            issue_fetch(2'b01, 3, 32'h0000_4000, 32'h0);
            n = 0;
            while (!(rd_active && rbeat >= 10) && n < 500) begin
                @(negedge clk);
                n++;
            end
            check_val("reached_beat10", 64'(rd_active && rbeat >= 10), 64'd1);
            #1;
            rst_n = 1'b0;
            #1;
            check_quiet("midreset");
            req_q.delete();
            exp_q.delete();
            mw_q.delete();
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        do_fetch(2'b01, 0, 32'h0000_5000, 32'h0, 2 + LW);

`ifdef LINE_FILL_PERF_CNT_EN
        check_val("perf_fetch", 64'(perf_fetch_cnt), 64'd1);
        check_val("perf_wb", 64'(perf_wb_cnt), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
